// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command-driven sequencer for the 4-bit combinational ALU. Accepts
// LOAD / EXEC / MUL / READ commands over a valid/ready handshake, drives the
// ALU operands, keeps the result in a 4-bit accumulator and returns each
// result over a second valid/ready handshake.
// MUL is a shift-and-add over MUL_STEPS (fixed at 4) ALU add/pass cycles.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds the rsp_zero output.
// All ALU drive signals and response outputs come straight from registers;
// cmd_ready is the registered ready gated low while reset is asserted.

module alu_op_sequencer #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_sel,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [3:0] alu_select,
  input  logic [3:0] alu_out,
  input  logic       alu_c_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic       rsp_zero,
`endif
  output logic [3:0] acc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_EXEC  = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [3:0] SEL_PASS = 4'b0000;  // out = x
  localparam logic [3:0] SEL_ADD  = 4'b0010;  // out = x + y

  // Index of the final multiply step (elaboration-time constant).
  localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

  // Ripple increment of the 2-bit step counter built from half adders.
  function automatic logic [1:0] step_inc(input logic [1:0] s);
    logic c0;
    c0 = s[0];
    step_inc = {s[1] ^ c0, s[0] ^ 1'b1};
  endfunction

  // Multiplicand shifted left by the step index, truncated to 4 bits (wiring only).
  function automatic logic [3:0] mcand_shift(input logic [3:0] m, input logic [1:0] sh);
    case (sh)
      2'b00:   mcand_shift = m;
      2'b01:   mcand_shift = {m[2:0], 1'b0};
      2'b10:   mcand_shift = {m[1:0], 2'b00};
      2'b11:   mcand_shift = {m[0], 3'b000};
      default: mcand_shift = m;
    endcase
  endfunction

  state_t     state_r, state_nxt_s;
  logic [3:0] acc_r, acc_nxt_s;
  logic       carry_r, carry_nxt_s;
  logic [3:0] mcand_r, mcand_nxt_s;
  logic [3:0] mplier_r, mplier_nxt_s;
  logic [1:0] step_r, step_nxt_s;
  // During MUL, alu_x_r doubles as the partial product P.
  logic [3:0] alu_x_r, alu_x_nxt_s;
  logic [3:0] alu_y_r, alu_y_nxt_s;
  logic [3:0] alu_sel_r, alu_sel_nxt_s;
  logic       rsp_valid_r, rsp_valid_nxt_s;
  logic [3:0] rsp_data_r, rsp_data_nxt_s;
  logic       rsp_carry_r, rsp_carry_nxt_s;
  logic       cmd_ready_r, cmd_ready_nxt_s;
  logic [1:0] step_up_s;
  logic       carry_sticky_s;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       rsp_zero_r, rsp_zero_nxt_s;
`endif

  assign step_up_s      = step_inc(step_r);
  assign carry_sticky_s = carry_r | alu_c_out;

  // Next-state, next-operand and next-response decode for every state.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    carry_nxt_s     = carry_r;
    mcand_nxt_s     = mcand_r;
    mplier_nxt_s    = mplier_r;
    step_nxt_s      = step_r;
    alu_x_nxt_s     = alu_x_r;
    alu_y_nxt_s     = alu_y_r;
    alu_sel_nxt_s   = alu_sel_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_data_nxt_s  = rsp_data_r;
    rsp_carry_nxt_s = rsp_carry_r;
    cmd_ready_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          case (cmd_op)
            OP_LOAD: begin
              acc_nxt_s       = cmd_data;
              carry_nxt_s     = 1'b0;
              alu_x_nxt_s     = cmd_data;
              alu_y_nxt_s     = 4'b0000;
              alu_sel_nxt_s   = SEL_PASS;
              rsp_valid_nxt_s = 1'b1;
              rsp_data_nxt_s  = cmd_data;
              rsp_carry_nxt_s = 1'b0;
              state_nxt_s     = ST_RESP;
            end
            OP_READ: begin
              rsp_valid_nxt_s = 1'b1;
              rsp_data_nxt_s  = acc_r;
              rsp_carry_nxt_s = carry_r;
              state_nxt_s     = ST_RESP;
            end
            OP_EXEC: begin
              alu_x_nxt_s   = acc_r;
              alu_y_nxt_s   = cmd_data;
              alu_sel_nxt_s = cmd_sel;
              state_nxt_s   = ST_EXEC;
            end
            OP_MUL: begin
              mcand_nxt_s   = acc_r;
              mplier_nxt_s  = cmd_data;
              step_nxt_s    = 2'b00;
              carry_nxt_s   = 1'b0;
              alu_x_nxt_s   = 4'b0000;
              alu_y_nxt_s   = acc_r;
              alu_sel_nxt_s = cmd_data[0] ? SEL_ADD : SEL_PASS;
              state_nxt_s   = ST_MUL;
            end
            default: begin
              cmd_ready_nxt_s = 1'b1;
            end
          endcase
        end else begin
          cmd_ready_nxt_s = 1'b1;
        end
      end

      ST_EXEC: begin
        acc_nxt_s       = alu_out;
        carry_nxt_s     = alu_c_out;
        alu_x_nxt_s     = alu_out;
        alu_y_nxt_s     = 4'b0000;
        alu_sel_nxt_s   = SEL_PASS;
        rsp_valid_nxt_s = 1'b1;
        rsp_data_nxt_s  = alu_out;
        rsp_carry_nxt_s = alu_c_out;
        state_nxt_s     = ST_RESP;
      end

      ST_MUL: begin
        carry_nxt_s = carry_sticky_s;
        if (step_r == LAST_STEP) begin
          acc_nxt_s       = alu_out;
          alu_x_nxt_s     = alu_out;
          alu_y_nxt_s     = 4'b0000;
          alu_sel_nxt_s   = SEL_PASS;
          rsp_valid_nxt_s = 1'b1;
          rsp_data_nxt_s  = alu_out;
          rsp_carry_nxt_s = carry_sticky_s;
          state_nxt_s     = ST_RESP;
        end else begin
          step_nxt_s    = step_up_s;
          alu_x_nxt_s   = alu_out;
          alu_y_nxt_s   = mcand_shift(mcand_r, step_up_s);
          alu_sel_nxt_s = mplier_r[step_up_s] ? SEL_ADD : SEL_PASS;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          cmd_ready_nxt_s = 1'b1;
          state_nxt_s     = ST_IDLE;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end

      default: begin
        rsp_valid_nxt_s = 1'b0;
        cmd_ready_nxt_s = 1'b1;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  // Zero flag follows the response that will be presented next cycle.
  always_comb begin
    rsp_zero_nxt_s = 1'b0;
    if (rsp_valid_nxt_s && (rsp_data_nxt_s == 4'b0000)) begin
      rsp_zero_nxt_s = 1'b1;
    end else begin
      rsp_zero_nxt_s = 1'b0;
    end
  end

  // Zero flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_zero_r <= 1'b0;
    end else begin
      rsp_zero_r <= rsp_zero_nxt_s;
    end
  end

  assign rsp_zero = rsp_zero_r;
`endif

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= 4'b0000;
      carry_r     <= 1'b0;
      mcand_r     <= 4'b0000;
      mplier_r    <= 4'b0000;
      step_r      <= 2'b00;
      alu_x_r     <= 4'b0000;
      alu_y_r     <= 4'b0000;
      alu_sel_r   <= SEL_PASS;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 4'b0000;
      rsp_carry_r <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      carry_r     <= carry_nxt_s;
      mcand_r     <= mcand_nxt_s;
      mplier_r    <= mplier_nxt_s;
      step_r      <= step_nxt_s;
      alu_x_r     <= alu_x_nxt_s;
      alu_y_r     <= alu_y_nxt_s;
      alu_sel_r   <= alu_sel_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_carry_r <= rsp_carry_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
    end
  end

  assign cmd_ready  = cmd_ready_r & ~reset;
  assign alu_x      = alu_x_r;
  assign alu_y      = alu_y_r;
  assign alu_select = alu_sel_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_carry  = rsp_carry_r;
  assign acc        = acc_r;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential initiator for the team's 4-bit combinational ALU: drives its x/y/select inputs, samples its out/c_out, and holds the result in a 4-bit accumulator.
- Accepts commands over a valid/ready handshake and returns results over a second valid/ready handshake.
- Supports a multi-cycle 4-bit multiply built only from repeated ALU add/pass operations.
- Sits between a command source (testbench or control FSM) and one ALU instance.

Parameters:
- MUL_STEPS, 4, number of multiply iterations. Fixed at 4 for 4-bit operands; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block accepts a command this cycle
- cmd_op  input  2  00 LOAD, 01 EXEC, 10 MUL, 11 READ
- cmd_sel  input  4  ALU select for EXEC; ignored otherwise
- cmd_data  input  4  operand (y for EXEC, multiplier for MUL, value for LOAD)
- alu_x  output  4  to ALU x
- alu_y  output  4  to ALU y
- alu_select  output  4  to ALU select
- alu_out  input  4  from ALU out
- alu_c_out  input  1  from ALU carry out
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_data  output  4  result
- rsp_carry  output  1  carry/flag for result
- acc  output  4  current accumulator

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state IDLE, acc=0, carry flag=0, rsp_valid=0, rsp_data=0, rsp_carry=0. cmd_ready is forced 0 while reset is high.
- ALU contract when select[3]=0: out = x + ((y&{4{s1}})|(~y&{4{s2}})) + s0.
  - Resulting operations: 0000 x, 0001 x+1, 0010 x+y, 0011 x+y+1, 0100 x-y-1, 0101 x-y, 0110 x-1, 0111 x (+carry).
- ALU contract when select[3]=1, selected by s[1:0]: 00 AND, 01 OR, 10 XOR, 11 NOT x.
- No arithmetic operators are used in the RTL. The step counter uses the same gate/adder style as the ALU; the multiplicand shift is pure wiring.
- States are IDLE, EXEC, MUL, RESP.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) at clock edge N latches op/sel/data.
  - LOAD: acc<=data, carry<=0, go to RESP.
  - READ: go to RESP with rsp_data=acc and rsp_carry=current carry flag.
  - EXEC: go to EXEC.
  - MUL: clear partial product P and step count, latch multiplicand M=acc, go to MUL.
- EXEC (exactly one cycle):
  - Drives alu_x=acc, alu_y=data, alu_select=sel.
  - At the end of that cycle: acc<=alu_out, carry<=alu_c_out. Go to RESP.
  - rsp_valid is first high in cycle N+2.
- MUL (exactly 4 cycles, step i=0..3):
  - Drives alu_x=P, alu_y=M<<i (low 4 bits), alu_select=0010 if data[i] else 0000.
  - Each edge: P<=alu_out; carry is a sticky OR of alu_c_out over the 4 steps.
  - After step 3: acc<=P, go to RESP. rsp_valid is first high in cycle N+5.
- Outside EXEC and MUL: alu_x=acc, alu_y=0, alu_select=0000.
- RESP:
  - rsp_valid=1; rsp_data=acc and rsp_carry=carry, both stable until taken.
  - cmd_ready=0.
  - rsp_ready high at an edge returns the block to IDLE. The earliest following command is accepted one cycle later (no response/command overlap).
- Back-pressure: rsp_valid, rsp_data and rsp_carry are held indefinitely while rsp_ready=0.
- cmd_valid while not in IDLE is ignored. The command source holds it until cmd_ready.
- Reset asserted mid-EXEC/MUL/RESP: immediately returns to IDLE with reset values. A partial multiply is discarded and no response is issued.
- Wrap-around: all results are modulo 16. Overflow shows only through the carry rules above.

Optional Feature:
- Macro ALU_SEQ_ZERO_FLAG_EN.
- When defined: adds output rsp_zero (1 bit), =1 iff rsp_data==0 while rsp_valid=1, 0 otherwise; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then LOAD data=9; EXEC sel=0010 data=8 -> rsp_data=1, rsp_carry=1, rsp_valid first high 2 cycles after accept.
- LOAD 3; EXEC sel=0101 data=5 -> rsp_data=14, rsp_carry=0. Then READ -> rsp_data=14, rsp_carry=0.
- LOAD 7; MUL data=3 -> rsp_data=5, rsp_carry=1, latency 5 cycles. LOAD 3; MUL data=5 -> rsp_data=15, rsp_carry=0.
- EXEC sel=1110 (XOR) with acc=12, data=10 -> rsp_data=6. Hold rsp_ready=0 for 5 cycles -> rsp_data and rsp_valid stable; cmd_ready=0 throughout.
- Assert reset at MUL step 2 -> acc=0, rsp_valid=0 immediately; after release cmd_ready=1 and no stale response appears.
- With ALU_SEQ_ZERO_FLAG_EN: LOAD 4; EXEC sel=0101 data=4 -> rsp_data=0, rsp_zero=1, rsp_carry=1.
